// File: rtl/banked_ram.sv
// banked_ram: NBANKS block-RAM banks behind one word address; unpopulated banks read 0 and raise err.
// Latency: 1-cycle registered read (read-first on collision), a write is readable on the next access.
// Backpressure: none except busy; `define BANKED_RAM_CLEAR_EN adds the post-reset zero sweep.
module banked_ram #(
   parameter int WIDTH   = 16,
   parameter int BANK_AW = 9,
   parameter int NBANKS  = 7,
   parameter int ADDR_W  = 12
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [ADDR_W-1:0] address,
   input  logic [WIDTH-1:0]  in,
   input  logic              load,
   output logic [WIDTH-1:0]  out,
   output logic              err,
   output logic              busy
);
   localparam int BANK_W = ADDR_W - BANK_AW;
   localparam logic [BANK_W:0] NB = (BANK_W+1)'(NBANKS);

   logic [BANK_W-1:0]       bank;
   logic [BANK_AW-1:0]      loc;
   logic                    in_range;
   logic                    acc_ok;
   logic                    clr;
   logic [BANK_AW-1:0]      wr_addr;
   logic [WIDTH-1:0]        wr_dat;
   logic [NBANKS*WIDTH-1:0] rd_dat;
   logic [BANK_W-1:0]       bank_q;
   logic                    rd_vld;
   logic [WIDTH-1:0]        rd_mux;

   assign bank     = address[ADDR_W-1:BANK_AW];
   assign loc      = address[BANK_AW-1:0];
   assign in_range = {1'b0, bank} < NB;
   assign acc_ok   = resetn && !busy;

`ifdef BANKED_RAM_CLEAR_EN
   typedef enum logic {CLEAR, IDLE} state_t;
   state_t             state;
   logic [BANK_AW-1:0] ptr;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= CLEAR;
         ptr   <= '0;
      end else if (state == CLEAR) begin
         ptr <= ptr + BANK_AW'(1);
         if (ptr == '1)
            state <= IDLE;
      end
   end

   assign busy    = (state == CLEAR);
   assign clr     = busy;
   assign wr_addr = busy ? ptr : loc;
   assign wr_dat  = busy ? '0 : in;
`else
   assign busy    = 1'b0;
   assign clr     = 1'b0;
   assign wr_addr = loc;
   assign wr_dat  = in;
`endif

   // Each bank is a plain read-first BRAM; the sweep writes every bank at ptr in parallel.
   for (genvar b = 0; b < NBANKS; b++) begin : g_bank
      logic [WIDTH-1:0] ram [2**BANK_AW];
      logic [WIDTH-1:0] q;
      logic             we;

      assign we = clr || (acc_ok && load && in_range && bank == BANK_W'(b));

      always_ff @(posedge clk) begin
         if (we)
            ram[wr_addr] <= wr_dat;
         q <= ram[loc];
      end

      assign rd_dat[b*WIDTH +: WIDTH] = q;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_vld <= 1'b0;
         err    <= 1'b0;
         bank_q <= '0;
      end else begin
         rd_vld <= !busy && in_range;
         err    <= !busy && !in_range;
         bank_q <= bank;
      end
   end

   // Unpopulated bank slots fall through to 0; rd_vld also forces 0 while busy or after reset.
   always_comb begin
      rd_mux = '0;
      for (int b = 0; b < NBANKS; b++)
         if (bank_q == BANK_W'(b))
            rd_mux = rd_dat[b*WIDTH +: WIDTH];
   end

   assign out = rd_vld ? rd_mux : '0;

endmodule
